// File: rtl/ld_st_mem_unit.sv
// Load/store memory access stage: one lw/sw at a time against a local word memory,
// fixed access latency, result broadcast on the CDB tagged with its ROB entry.
module ld_st_mem_unit #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned ADDR_BITS   = 10,
    parameter logic [11:0] OPC_LW      = 12'h003,
    parameter logic [11:0] OPC_SW      = 12'h023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        VALID_Inst,
    output logic        in_READY,
    input  logic [4:0]  ROBEN,
    input  logic [4:0]  Rd,
    input  logic [11:0] opcode,
    input  logic [31:0] EA,
    input  logic [31:0] ROBEN2_VAL,
    input  logic        ROB_FLUSH_Flag,
    input  logic        CDB_ack,
    output logic        out_VALID,
    output logic [4:0]  out_ROBEN,
    output logic [4:0]  out_Rd,
    output logic [31:0] out_VAL,
    output logic        out_is_store
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [4:0]             roben_q;
    logic [4:0]             rd_q;
    logic                   is_store_q;
    logic                   flushed_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [31:0]            sdata_q;
    logic                   out_valid_q;
    logic [4:0]             out_roben_q;
    logic [4:0]             out_rd_q;
    logic [31:0]            out_val_q;
    logic                   out_is_store_q;

    logic [31:0]            mem [1 << ADDR_BITS];

    logic                   is_mem_op;
    logic                   mem_we;
    logic                   unused_ea;

    assign is_mem_op = (opcode == OPC_LW) || (opcode == OPC_SW);
    assign mem_we    = (state_q == S_ACCESS) && (cnt_q == '0) && is_store_q;
    assign unused_ea = ^EA[31:ADDR_BITS];

    assign in_READY     = (state_q == S_IDLE);
    assign out_VALID    = out_valid_q;
    assign out_ROBEN    = out_roben_q;
    assign out_Rd       = out_rd_q;
    assign out_VAL      = out_val_q;
    assign out_is_store = out_is_store_q;

    // Memory is deliberately not reset; a reset during ACCESS drops state to IDLE so mem_we never fires.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= sdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            roben_q        <= '0;
            rd_q           <= '0;
            is_store_q     <= 1'b0;
            flushed_q      <= 1'b0;
            idx_q          <= '0;
            sdata_q        <= '0;
            out_valid_q    <= 1'b0;
            out_roben_q    <= '0;
            out_rd_q       <= '0;
            out_val_q      <= '0;
            out_is_store_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (VALID_Inst && !ROB_FLUSH_Flag && is_mem_op) begin
                        roben_q    <= ROBEN;
                        rd_q       <= Rd;
                        is_store_q <= (opcode == OPC_SW);
                        idx_q      <= EA[ADDR_BITS-1:0];
                        sdata_q    <= ROBEN2_VAL;
                        cnt_q      <= CNT_INIT;
                        flushed_q  <= 1'b0;
                        state_q    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!is_store_q && ROB_FLUSH_Flag) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        // A store flushed at any point in ACCESS still writes but skips its broadcast.
                        if (flushed_q || ROB_FLUSH_Flag) begin
                            state_q <= S_IDLE;
                        end else begin
                            out_valid_q    <= 1'b1;
                            out_roben_q    <= roben_q;
                            out_rd_q       <= rd_q;
                            out_is_store_q <= is_store_q;
                            out_val_q      <= is_store_q ? sdata_q : mem[idx_q];
                            state_q        <= S_WB;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (ROB_FLUSH_Flag) begin
                            flushed_q <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (ROB_FLUSH_Flag || CDB_ack) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ld_st_mem_unit.sv
// Bench for ld_st_mem_unit: directed vector table, flush/reset sequences, randomized
// traffic against a word-indexed memory model.
module tb_ld_st_mem_unit;

    localparam int unsigned L     = 2;
    localparam int unsigned AB    = 10;
    localparam int unsigned DEPTH = 1 << AB;
    localparam logic [11:0] LW    = 12'h003;
    localparam logic [11:0] SW    = 12'h023;
    localparam logic [11:0] BAD   = 12'h7FF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        VALID_Inst = 1'b0;
    logic        in_READY;
    logic [4:0]  ROBEN = '0;
    logic [4:0]  Rd = '0;
    logic [11:0] opcode = '0;
    logic [31:0] EA = '0;
    logic [31:0] ROBEN2_VAL = '0;
    logic        ROB_FLUSH_Flag = 1'b0;
    logic        CDB_ack = 1'b0;
    logic        out_VALID;
    logic [4:0]  out_ROBEN;
    logic [4:0]  out_Rd;
    logic [31:0] out_VAL;
    logic        out_is_store;

    ld_st_mem_unit #(
        .MEM_LATENCY(L),
        .ADDR_BITS  (AB),
        .OPC_LW     (LW),
        .OPC_SW     (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .VALID_Inst    (VALID_Inst),
        .in_READY      (in_READY),
        .ROBEN         (ROBEN),
        .Rd            (Rd),
        .opcode        (opcode),
        .EA            (EA),
        .ROBEN2_VAL    (ROBEN2_VAL),
        .ROB_FLUSH_Flag(ROB_FLUSH_Flag),
        .CDB_ack       (CDB_ack),
        .out_VALID     (out_VALID),
        .out_ROBEN     (out_ROBEN),
        .out_Rd        (out_Rd),
        .out_VAL       (out_VAL),
        .out_is_store  (out_is_store)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] mdl [int unsigned];

    typedef struct {
        logic [11:0] op;
        logic [31:0] ea;
        logic [31:0] data;
        logic [4:0]  roben;
        logic [4:0]  rd;
        int unsigned ackd;
        logic        bcast;
        logic [31:0] val;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        while (!in_READY && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", in_READY, 1);
    endtask

    task automatic wait_valid(output int unsigned n);
        n = 0;
        while (!out_VALID && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Drives one request at a negedge and follows it to completion on the CDB.
    task automatic run_txn(input logic [11:0] op, input logic [31:0] ea, input logic [31:0] data,
                           input logic [4:0] rb, input logic [4:0] r, input int unsigned ackd,
                           input logic bc, input logic [31:0] ev);
        int unsigned n;
        wait_ready();
        opcode = op; EA = ea; ROBEN2_VAL = data; ROBEN = rb; Rd = r;
        VALID_Inst = 1'b1;
        CDB_ack = (ackd == 0);
        @(negedge clk);
        VALID_Inst = 1'b0;
        if (!bc) begin
            chk("drop_ready", in_READY, 1);
            chk("drop_valid", out_VALID, 0);
            CDB_ack = 1'b0;
            return;
        end
        chk("busy_ready", in_READY, 0);
        wait_valid(n);
        chk("latency", n, L);
        chk("val", out_VAL, ev);
        chk("roben", out_ROBEN, rb);
        chk("rd", out_Rd, r);
        chk("is_store", out_is_store, op == SW);
        for (int unsigned i = 0; i < ackd; i++) begin
            @(negedge clk);
            chk("hold_valid", out_VALID, 1);
            chk("hold_val", out_VAL, ev);
            chk("hold_roben", out_ROBEN, rb);
            chk("hold_ready", in_READY, 0);
        end
        CDB_ack = 1'b1;
        @(negedge clk);
        CDB_ack = 1'b0;
        chk("release_valid", out_VALID, 0);
        chk("release_ready", in_READY, 1);
        if (op == SW) mdl[ea % DEPTH] = data;
    endtask

    initial begin
        vec_t        tv[$];
        int unsigned n;
        logic        seen;
        logic [31:0] d, ea;
        int unsigned k, ackd;

        repeat (2) @(negedge clk);
        chk("rst_valid", out_VALID, 0);
        chk("rst_roben", out_ROBEN, 0);
        chk("rst_rd", out_Rd, 0);
        chk("rst_val", out_VAL, 0);
        chk("rst_store", out_is_store, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", in_READY, 1);

        tv.push_back('{SW,  32'h0000_0010, 32'hDEAD_BEEF,  5'd3,  5'd0, 0, 1'b1, 32'hDEAD_BEEF});
        tv.push_back('{LW,  32'h0000_0010, 32'h0,          5'd4,  5'd7, 0, 1'b1, 32'hDEAD_BEEF});
        tv.push_back('{LW,  32'h0000_0410, 32'h0,          5'd5,  5'd8, 0, 1'b1, 32'hDEAD_BEEF});
        tv.push_back('{SW,  32'h0000_03FF, 32'h1234_5678,  5'd6,  5'd1, 1, 1'b1, 32'h1234_5678});
        tv.push_back('{LW,  32'hFFFF_FFFF, 32'h0,          5'd7,  5'd9, 0, 1'b1, 32'h1234_5678});
        tv.push_back('{BAD, 32'h0000_0010, 32'h5555_5555,  5'd8,  5'd2, 0, 1'b0, 32'h0});
        tv.push_back('{LW,  32'h0000_0010, 32'h0,          5'd9,  5'd3, 5, 1'b1, 32'hDEAD_BEEF});
        tv.push_back('{SW,  32'h0000_0020, 32'hA5A5_A5A5,  5'd31, 5'd31, 2, 1'b1, 32'hA5A5_A5A5});
        tv.push_back('{LW,  32'h0000_0020, 32'h0,          5'd1,  5'd4, 0, 1'b1, 32'hA5A5_A5A5});
        foreach (tv[i]) begin
            run_txn(tv[i].op, tv[i].ea, tv[i].data, tv[i].roben, tv[i].rd, tv[i].ackd, tv[i].bcast, tv[i].val);
        end

        // load flushed in ACCESS
        wait_ready();
        opcode = LW; EA = 32'h10; ROBEN = 5'd9; Rd = 5'd2; VALID_Inst = 1'b1; CDB_ack = 1'b0;
        @(negedge clk);
        VALID_Inst = 1'b0; ROB_FLUSH_Flag = 1'b1;
        @(negedge clk);
        ROB_FLUSH_Flag = 1'b0;
        chk("lwflush_ready", in_READY, 1);
        chk("lwflush_valid", out_VALID, 0);
        seen = 1'b0;
        repeat (L + 2) begin @(negedge clk); if (out_VALID) seen = 1'b1; end
        chk("lwflush_nobcast", seen, 0);
        run_txn(LW, 32'h10, 32'h0, 5'd10, 5'd5, 0, 1'b1, 32'hDEAD_BEEF);

        // store flushed in ACCESS: write lands, no broadcast
        wait_ready();
        opcode = SW; EA = 32'h30; ROBEN2_VAL = 32'hCAFE_F00D; ROBEN = 5'd10; Rd = 5'd0; VALID_Inst = 1'b1;
        @(negedge clk);
        VALID_Inst = 1'b0; ROB_FLUSH_Flag = 1'b1;
        @(negedge clk);
        ROB_FLUSH_Flag = 1'b0;
        seen = 1'b0; n = 0;
        while (!in_READY && n < 20) begin
            if (out_VALID) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        repeat (2) begin if (out_VALID) seen = 1'b1; @(negedge clk); end
        chk("swflush_nobcast", seen, 0);
        chk("swflush_ready", in_READY, 1);
        mdl[32'h30] = 32'hCAFE_F00D;
        run_txn(LW, 32'h30, 32'h0, 5'd11, 5'd3, 0, 1'b1, 32'hCAFE_F00D);

        // flush in IDLE masks a same-cycle request
        wait_ready();
        opcode = LW; EA = 32'h10; ROBEN = 5'd12; VALID_Inst = 1'b1; ROB_FLUSH_Flag = 1'b1;
        @(negedge clk);
        VALID_Inst = 1'b0; ROB_FLUSH_Flag = 1'b0;
        chk("idleflush_ready", in_READY, 1);
        seen = 1'b0;
        repeat (L + 2) begin @(negedge clk); if (out_VALID || !in_READY) seen = 1'b1; end
        chk("idleflush_ignored", seen, 0);

        // flush together with ack in WB
        wait_ready();
        opcode = LW; EA = 32'h410; ROBEN = 5'd13; Rd = 5'd4; VALID_Inst = 1'b1; CDB_ack = 1'b0;
        @(negedge clk);
        VALID_Inst = 1'b0;
        wait_valid(n);
        chk("wbflush_valid_up", out_VALID, 1);
        ROB_FLUSH_Flag = 1'b1; CDB_ack = 1'b1;
        @(negedge clk);
        ROB_FLUSH_Flag = 1'b0; CDB_ack = 1'b0;
        chk("wbflush_valid", out_VALID, 0);
        chk("wbflush_ready", in_READY, 1);
        repeat (2) @(negedge clk);
        chk("wbflush_stay", out_VALID, 0);

        // async reset in the middle of a store's ACCESS
        run_txn(SW, 32'h40, 32'h1111_1111, 5'd14, 5'd6, 0, 1'b1, 32'h1111_1111);
        wait_ready();
        opcode = SW; EA = 32'h40; ROBEN2_VAL = 32'h2222_2222; ROBEN = 5'd15; VALID_Inst = 1'b1;
        @(negedge clk);
        VALID_Inst = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", out_VALID, 0);
        chk("arst_roben", out_ROBEN, 0);
        chk("arst_rd", out_Rd, 0);
        chk("arst_val", out_VAL, 0);
        chk("arst_store", out_is_store, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_ready", in_READY, 1);
        run_txn(LW, 32'h40, 32'h0, 5'd16, 5'd7, 0, 1'b1, 32'h1111_1111);

        // randomized traffic over a small aliased address window
        for (int unsigned i = 0; i < 8; i++) begin
            d = $urandom;
            run_txn(SW, 32'h50 + i, d, 5'(i + 1), 5'd0, 0, 1'b1, d);
        end
        for (int unsigned i = 0; i < 60; i++) begin
            k    = $urandom_range(0, 9);
            ea   = ($urandom << AB) | (32'h50 + $urandom_range(0, 7));
            d    = $urandom;
            ackd = $urandom_range(0, 3);
            if (k < 4)
                run_txn(LW, ea, d, 5'($urandom), 5'($urandom), ackd, 1'b1, mdl[ea % DEPTH]);
            else if (k < 8)
                run_txn(SW, ea, d, 5'($urandom), 5'($urandom), ackd, 1'b1, d);
            else
                run_txn(BAD, ea, d, 5'($urandom), 5'($urandom), ackd, 1'b0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
